// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Runs 32 shift-add / restoring-divide steps, then a sign-fix cycle that writes HI/LO.
//
// state  | meaning
// IDLE   | accepts start; performs MTHI/MTLO directly
// RUN    | one multiply/divide iteration per edge, counter 0..31
// FIX    | sign correction, HI/LO write, done pulse
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_md_start,
  input  logic [2:0]       ex_md_op,
  input  logic [WIDTH-1:0] ex_md_a,
  input  logic [WIDTH-1:0] ex_md_b,
  input  logic             ex_md_flush,
  output logic             ex_md_busy,
  output logic             ex_md_done,
  output logic [WIDTH-1:0] ex_hiout,
  output logic [WIDTH-1:0] ex_loout
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [5:0]           r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_is_div;
  logic                 r_dbz;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_is_md;
  logic                 w_is_mt;
  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_b_zero;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_step;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_rem_sub;
  logic                 w_q_bit;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;

  assign w_is_md  = ~ex_md_op[2];
  assign w_is_mt  = (ex_md_op[2:1] == 2'b10);
  assign w_is_div = ex_md_op[1];
  assign w_signed = ~ex_md_op[0];
  assign w_b_zero = (ex_md_b == '0);
  assign w_accept = (r_state == S_IDLE) & ex_md_start & ~ex_md_flush;

  assign w_abs_a = (w_signed & ex_md_a[WIDTH-1]) ? -ex_md_a : ex_md_a;
  assign w_abs_b = (w_signed & ex_md_b[WIDTH-1]) ? -ex_md_b : ex_md_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: shifted remainder needs one extra bit for the compare
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_rem_sub  = w_rem_sh - {1'b0, r_opnd};
  assign w_q_bit    = (w_rem_sh >= {1'b0, r_opnd});
  assign w_div_step = w_q_bit ? {w_rem_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                              : {w_rem_sh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_md) w_state_nxt = (w_is_div && w_b_zero) ? S_FIX : S_RUN;
      S_RUN: begin
        if (ex_md_flush)          w_state_nxt = S_IDLE;
        else if (r_cnt == 6'd31)  w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ex_md_busy = rst_n & ((r_state != S_IDLE) | (w_accept & w_is_md));
    ex_md_done = rst_n & (r_state == S_FIX) & ~ex_md_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_dbz    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_md) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_dbz    <= w_is_div & w_b_zero;
            r_neg_q  <= w_signed & (ex_md_a[WIDTH-1] ^ ex_md_b[WIDTH-1]);
            r_neg_r  <= w_signed & ex_md_a[WIDTH-1];
            if (w_is_div) begin
              // divide-by-zero keeps the raw dividend for HI
              r_acc  <= {{WIDTH{1'b0}}, w_b_zero ? ex_md_a : w_abs_a};
              r_opnd <= w_abs_b;
            end else begin
              r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
              r_opnd <= w_abs_a;
            end
          end else if (w_accept && w_is_mt) begin
            if (ex_md_op[0]) r_lo <= ex_md_a;
            else             r_hi <= ex_md_a;
          end
        end
        S_RUN: begin
          if (!ex_md_flush) begin
            r_cnt <= r_cnt + 6'd1;
            r_acc <= r_is_div ? w_div_step : w_mul_step;
          end
        end
        S_FIX: begin
          if (!ex_md_flush) begin
            if (r_dbz) begin
              r_lo <= '1;
              r_hi <= r_acc[WIDTH-1:0];
            end else if (r_is_div) begin
              r_lo <= w_quot;
              r_hi <= w_rem;
            end else begin
              r_lo <= w_prod[WIDTH-1:0];
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ex_hiout = r_hi;
  assign ex_loout = r_lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv: results, busy/done timing,
// flush, divide-by-zero and asynchronous reset behaviour.
module tb_ex_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errs;
  int checks;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_md_start(start),
    .ex_md_op   (op),
    .ex_md_a    (a),
    .ex_md_b    (b),
    .ex_md_flush(flush),
    .ex_md_busy (busy),
    .ex_md_done (done),
    .ex_hiout   (hi),
    .ex_loout   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one mul/div at the next negedge and follow it until busy drops.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                        input int ebusy);
    int n;
    int dn;
    int dat;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    #1;
    n = 0; dn = 0; dat = -1;
    while (busy && n < 200) begin
      if (done) begin dn++; dat = n; end
      n++;
      @(negedge clk);
      start = 1'b0;
      #1;
    end
    chk({tag, " busy_cycles"}, 64'(n), 64'(ebusy));
    chk({tag, " done_count"}, 64'(dn), 64'd1);
    chk({tag, " done_cycle"}, 64'(dat), 64'(ebusy - 1));
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    int dn;
    errs = 0; checks = 0;
    start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;

    // reset with a pending MULT request: busy must stay low
    rst_n = 1'b0;
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
    #12;
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst hi", {32'd0, hi}, 64'd0);
    chk("rst lo", {32'd0, lo}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_md("mult_m3x7",  3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 34);
    run_md("multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    run_md("mult_min2",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34);
    run_md("div_m7_2",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run_md("divu_7_2",   3'b011, 32'd7,        32'd2,        32'd1,        32'd3,        34);
    run_md("div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34);
    run_md("div_7_m2",   3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 34);
    run_md("div_by0",    3'b010, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 2);
    run_md("divu_by0",   3'b011, 32'hF0000005, 32'd0,        32'hF0000005, 32'hFFFFFFFF, 2);

    // MTHI / MTLO
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hAAAA;
    #1 chk("mthi busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    op = 3'b101; a = 32'h5555;
    #1 chk("mthi hi", {32'd0, hi}, 64'hAAAA);
    @(negedge clk);
    start = 1'b0;
    #1 chk("mtlo lo", {32'd0, lo}, 64'h5555);
    chk("mtlo done", {63'd0, done}, 64'd0);

    // flush during RUN at T+10
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush_run busy_at_t10", {63'd0, busy}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_run busy_at_t11", {63'd0, busy}, 64'd0);
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (done || busy) dn++;
    end
    chk("flush_run quiet", 64'(dn), 64'd0);
    chk("flush_run hi", {32'd0, hi}, 64'hAAAA);
    chk("flush_run lo", {32'd0, lo}, 64'h5555);

    run_md("multu_3x5", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 34);

    // flush in IDLE cancels MTLO
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'h1; flush = 1'b1;
    #1 chk("flush_mt busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 chk("flush_mt lo", {32'd0, lo}, 64'd15);

    // op 110 is a no-op
    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h77; b = 32'h3;
    #1 chk("nop busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("nop hi", {32'd0, hi}, 64'd0);
    chk("nop lo", {32'd0, lo}, 64'd15);

    // flush coincident with FIX wins
    @(negedge clk);
    start = 1'b1; op = 3'b001; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(negedge clk);
    #1 chk("flush_fix done_before", {63'd0, done}, 64'd1);
    flush = 1'b1;
    #1 chk("flush_fix done", {63'd0, done}, 64'd0);
    chk("flush_fix busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_fix lo", {32'd0, lo}, 64'd15);
    chk("flush_fix idle", {63'd0, busy}, 64'd0);

    // async reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("midrst busy", {63'd0, busy}, 64'd0);
    chk("midrst hi", {32'd0, hi}, 64'd0);
    chk("midrst lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_md("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 34);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit with the architectural HI/LO registers, sitting in the EX stage directly upstream of the Memory stage. It executes MULT/MULTU/DIV/DIVU over multiple cycles and holds the pipeline with `ex_md_busy` while it runs. It also performs single-cycle MTHI/MTLO writes. Its `ex_hiout`/`ex_loout` travel through EX/MEM into the Memory stage's `mem_hiout`/`mem_loout` writeback inputs.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_md_start` in 1: request; sampled only in IDLE.
- `ex_md_op` in 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- `ex_md_a` in 32: rs operand (dividend / multiplicand / MTHI-MTLO data).
- `ex_md_b` in 32: rt operand (divisor / multiplier).
- `ex_md_flush` in 1: exception abort.
- `ex_md_busy` out 1: pipeline stall request.
- `ex_md_done` out 1: one-cycle pulse when HI/LO are written by a mul/div.
- `ex_hiout` out 32: architectural HI.
- `ex_loout` out 32: architectural LO.

## Operation
- State machine: IDLE, RUN, FIX.
- **IDLE**
  - `start` with a mul/div op latches |a| and |b| (magnitudes for signed ops, raw for unsigned), the result signs, and op; clears the 6-bit counter; goes to RUN.
  - DIV/DIVU with b==0 goes straight to FIX.
- **RUN**: one iteration per edge, 32 iterations (counter 0..31), then FIX.
  - Multiply: shift-add. 64-bit accumulator; adds the multiplicand when the multiplier LSB is 1; shifts right one bit per cycle.
  - Divide: restoring. 64-bit {rem, quot} shifts left; subtracts the divisor when rem >= divisor and sets the quotient bit.
- **FIX**: one cycle; applies sign correction, writes HI/LO, pulses `done`, returns to IDLE.
  - MULT: the 64-bit product is negated when sign(a) XOR sign(b); HI=[63:32], LO=[31:0].
  - DIV: the quotient is negated when sign(a) XOR sign(b); the remainder takes the sign of a. LO=quotient, HI=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: LO=0xFFFFFFFF, HI=a, for both signed and unsigned.
- **MTHI/MTLO**: `start` in IDLE writes a to HI or LO at the next edge. No busy, no done, state stays IDLE.
- **Ignored requests**
  - `start` outside IDLE is ignored; the pipeline never issues one.
  - Op 110/111 does nothing.
- **Flush**
  - Flush in RUN or FIX returns to IDLE at the next edge. HI/LO are unchanged and no `done` is pulsed.
  - Flush in IDLE cancels a same-cycle `start`, including MTHI/MTLO.
  - Flush and FIX in the same cycle: flush wins.
- **Busy**: `busy` = (state != IDLE) | (state==IDLE & start & !flush & op is mul/div). The combinational term stalls the issuing instruction in its own cycle.
- **Outputs**: `ex_hiout`/`ex_loout` are the HI/LO registers directly, with no bypass of results still in flight.

## Timing
- Reset (`rst_n` low): HI=0, LO=0, state IDLE, counter 0, `done`=0, `busy`=0. Takes effect immediately, including mid-RUN; `busy` is forced 0 while `rst_n` is low.
- Mul/div with start in cycle T:
  - `busy` is high during cycles T..T+33 (34 cycles).
  - RUN covers T+1..T+32.
  - FIX is cycle T+33, with `done`=1 only in that cycle.
  - New HI/LO are visible from T+34.
- Divide by zero: `busy` is high during T..T+1, FIX is T+1, HI/LO update at T+2.
- MTHI/MTLO in cycle T: the new value is visible at T+1.
- A new `start` is accepted in the cycle after FIX (back-to-back allowed).

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB at T+34; `busy` high for exactly 34 cycles; `done` is a single pulse at T+33.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV a=0x1234, b=0 -> LO=0xFFFFFFFF, HI=0x1234 at T+2; `busy` high for 2 cycles.
- MULT started with HI/LO preloaded via MTHI=0xAAAA, MTLO=0x5555; `flush` at T+10 -> IDLE at T+11, HI/LO stay 0xAAAA/0x5555, no `done`; a following MULTU 3*5 gives LO=15, HI=0.
- `rst_n` pulled low at T+20 of a DIVU -> HI=LO=0 and `busy`=0 immediately; after release a new start completes normally.
